// File: rtl/mem_port_scheduler_pkg.sv
// Shared types and memory-interface widths for the memory port scheduler.
// The memory-defines header values are provided here when not already defined.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 5
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 32
`endif
`ifndef MEM_TAG_SRC_BIT
`define MEM_TAG_SRC_BIT 0
`endif

package mem_port_scheduler_pkg;
  localparam int ADDR_W      = `MEM_ADDR_BITS;
  localparam int TAG_W       = `MEM_TAG_BITS;
  localparam int DATA_W      = `MEM_DATA_BITS;
  localparam int TAG_SRC_BIT = `MEM_TAG_SRC_BIT;
  localparam int SEQ_W       = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WDATA = 1'b1
  } sched_state_e;

  // Source bit sits at the bottom, the wrapping sequence number directly above it.
  function automatic logic [TAG_W-1:0] make_tag(input logic [SEQ_W-1:0] seq, input logic src);
    logic [TAG_W-1:0] t;
    t            = '0;
    t[SEQ_W:1]   = seq;
    t[TAG_SRC_BIT] = src;
    return t;
  endfunction
endpackage

// File: rtl/mem_sched_credit_counter.sv
// Outstanding-request credit counter (saturating both ways) plus the
// response beat counter whose final beat releases one credit.
module mem_sched_credit_counter #(
  parameter int MAX_COUNT = 4,
  parameter int BEATS     = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                i_inc,
  input  logic                                i_beat,
  output logic [$clog2(MAX_COUNT+1)-1:0]      o_count,
  output logic [((BEATS > 1) ? $clog2(BEATS) : 1)-1:0] o_beat,
  output logic                                o_last_beat
);
  localparam int CW = $clog2(MAX_COUNT + 1);
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] COUNT_MAX = CW'(MAX_COUNT);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);

  logic [CW-1:0] r_count;
  logic [BW-1:0] r_beat;

  assign o_last_beat = i_beat && (r_beat == BEAT_LAST);
  assign o_count     = r_count;
  assign o_beat      = r_beat;

  // Simultaneous increment and release cancel; stale releases at zero are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_beat  <= '0;
    end else begin
      if (i_beat)
        r_beat <= (r_beat == BEAT_LAST) ? '0 : r_beat + 1'b1;
      if (i_inc && !o_last_beat && (r_count != COUNT_MAX))
        r_count <= r_count + 1'b1;
      else if (o_last_beat && !i_inc && (r_count != '0))
        r_count <= r_count - 1'b1;
    end
  end
endmodule

// File: rtl/mem_port_scheduler.sv
// Shares one main-memory port between icache and dcache with tagged responses.
// Define MEM_SCHED_PERF_EN to add grant/stall performance counters.
module mem_port_scheduler
  import mem_port_scheduler_pkg::*;
#(
  parameter int DATA_BEATS      = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req_valid,
  output logic              ic_req_ready,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_resp_valid,
  input  logic              dc_req_valid,
  output logic              dc_req_ready,
  input  logic              dc_req_rw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic              dc_data_valid,
  output logic              dc_data_ready,
  output logic              dc_resp_valid,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [TAG_W-1:0]  mem_req_tag,
  output logic              mem_req_data_valid,
  input  logic              mem_req_data_ready,
  input  logic              mem_resp_valid,
  input  logic [TAG_W-1:0]  mem_resp_tag
`ifdef MEM_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_ic_grants,
  output logic [31:0]       perf_dc_grants,
  output logic [31:0]       perf_stall_cycles
`endif
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(MAX_OUTSTANDING);
  localparam logic [BW-1:0] BEAT_LAST  = BW'(DATA_BEATS - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  sched_state_e     r_state, w_state_nxt;
  logic [CW-1:0]    w_credits;
  logic [BW-1:0]    w_rbeat_unused;
  logic [BW-1:0]    r_wbeat;
  logic [SW-1:0]    r_starve;
  logic [SEQ_W-1:0] r_seq;
  logic w_resp_last, w_has_credit, w_ic_elig, w_dc_elig, w_sel_dc, w_sel_valid;
  logic w_accept, w_acc_write, w_acc_read, w_in_wdata, w_wbeat_acc;

  mem_sched_credit_counter #(
    .MAX_COUNT (MAX_OUTSTANDING),
    .BEATS     (DATA_BEATS)
  ) u_credit (
    .clk         (clk),
    .reset       (reset),
    .i_inc       (w_acc_read),
    .i_beat      (mem_resp_valid),
    .o_count     (w_credits),
    .o_beat      (w_rbeat_unused),
    .o_last_beat (w_resp_last)
  );

  // A credit freed by this cycle's final response beat is usable immediately.
  always_comb begin
    w_has_credit = (w_credits < CREDIT_MAX) || w_resp_last;
    w_ic_elig    = ic_req_valid && w_has_credit;
    w_dc_elig    = dc_req_valid && (dc_req_rw || w_has_credit);
    w_sel_dc     = w_dc_elig && !(w_ic_elig && (r_starve == STARVE_MAX));
    w_sel_valid  = !reset && (r_state == ST_IDLE) && (w_sel_dc || w_ic_elig);
    w_accept     = w_sel_valid && mem_req_ready;
    w_acc_write  = w_accept && w_sel_dc && dc_req_rw;
    w_acc_read   = w_accept && !w_acc_write;
    w_in_wdata   = !reset && (r_state == ST_WDATA);
    w_wbeat_acc  = w_in_wdata && dc_data_valid && mem_req_data_ready;
  end

  assign mem_req_valid      = w_sel_valid;
  assign mem_req_rw         = w_sel_valid && w_sel_dc && dc_req_rw;
  assign mem_req_addr       = w_sel_valid ? (w_sel_dc ? dc_req_addr : ic_req_addr) : '0;
  assign mem_req_tag        = w_sel_valid ? make_tag(r_seq, w_sel_dc) : '0;
  assign ic_req_ready       = w_accept && !w_sel_dc;
  assign dc_req_ready       = w_accept && w_sel_dc;
  assign mem_req_data_valid = w_in_wdata && dc_data_valid;
  assign dc_data_ready      = w_in_wdata && mem_req_data_ready;
  assign ic_resp_valid      = !reset && mem_resp_valid && !mem_resp_tag[TAG_SRC_BIT];
  assign dc_resp_valid      = !reset && mem_resp_valid && mem_resp_tag[TAG_SRC_BIT];

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_acc_write) w_state_nxt = ST_WDATA;
      ST_WDATA: if (w_wbeat_acc && (r_wbeat == BEAT_LAST)) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Waiting during a write burst still counts as being denied.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wbeat  <= '0;
      r_seq    <= '0;
      r_starve <= '0;
    end else begin
      if (w_wbeat_acc)
        r_wbeat <= (r_wbeat == BEAT_LAST) ? '0 : r_wbeat + 1'b1;
      if (w_accept)
        r_seq <= r_seq + 1'b1;
      if (!ic_req_valid || ic_req_ready)
        r_starve <= '0;
      else if (r_starve != STARVE_MAX)
        r_starve <= r_starve + 1'b1;
    end
  end

`ifdef MEM_SCHED_PERF_EN
  logic [31:0] r_perf_ic, r_perf_dc, r_perf_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_ic    <= '0;
      r_perf_dc    <= '0;
      r_perf_stall <= '0;
    end else begin
      if (ic_req_ready) r_perf_ic <= r_perf_ic + 32'd1;
      if (dc_req_ready) r_perf_dc <= r_perf_dc + 32'd1;
      if ((ic_req_valid || dc_req_valid) && !(ic_req_ready || dc_req_ready))
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_ic_grants    = r_perf_ic;
  assign perf_dc_grants    = r_perf_dc;
  assign perf_stall_cycles = r_perf_stall;
`endif
endmodule
